trdb_branch_map: RTL and testbench
==================================

Name: trdb_branch_map

Overview:
- Upstream neighbour of the packet emitter; accumulates taken/not-taken outcomes of retired branches into the branch map consumed by format 0 and format 1 packets.
- Tracks the branch count and signals full so the format-selection logic forces a packet.
- Clears on a flush request issued when a packet consumes the map.
- One instance per trace encoder, between the retirement-interface filter and the packet emitter.

Parameters:
- MAP_LEN, 31, maximum number of branch outcomes held; E-Trace maximum.
- CNT_LEN, 5, width of the branch counter; must satisfy 2**CNT_LEN > MAP_LEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- branch_valid_i  in  1  a branch retired this cycle; one branch per cycle maximum
- branch_taken_i  in  1  outcome of that branch; 1 = taken; ignored when branch_valid_i = 0
- flush_i  in  1  packet carrying the current map is emitted this cycle; clear the map
- map_o  out  MAP_LEN  branch map; bit i = outcome of the i-th branch since last flush; encoding 1 = not taken, 0 = taken
- branches_o  out  CNT_LEN  number of valid bits in map_o, range 0..MAP_LEN
- is_full_o  out  1  branches_o == MAP_LEN
- is_empty_o  out  1  branches_o == 0
- overflow_o  out  1  one-cycle pulse: branch arrived while full without flush; outcome dropped

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: map_o = 0, branches_o = 0, overflow_o = 0. is_full_o = 0 and is_empty_o = 1 during reset.
- Registers: map and count registers; is_full_o and is_empty_o are combinational decodes of the count register; overflow_o is registered.
- Latency: an outcome presented in cycle N is visible on map_o/branches_o in cycle N+1.
- Flush consumption: the emitter samples map_o/branches_o in the same cycle flush_i is high, i.e. the pre-flush values.
- Recording a branch (branch_valid_i=1, flush_i=0, not full):
  - map[branches] <= ~branch_taken_i;
  - branches <= branches+1;
  - all other bits unchanged.
- Flush only (flush_i=1, branch_valid_i=0): map <= 0, branches <= 0.
- Simultaneous flush and branch: the flush applies first; the new outcome lands in bit 0:
  - map <= {0…, ~branch_taken_i};
  - branches <= 1.
  - The flushed packet does not contain this branch.
- Full without flush:
  - branch_valid_i=1, flush_i=0 with branches == MAP_LEN: map and count unchanged; overflow_o = 1 in the next cycle.
  - Protocol violation; the SVA checker flags it.
- Full with flush and branch: handled exactly as simultaneous flush and branch; no overflow.
- Flush while empty: legal no-op; registers stay 0.
- Bits above branches_o are always 0; the invariant holds after every transition.
- Count arithmetic: CNT_LEN unsigned, never wraps; saturation is guaranteed by the full check.
- Reset mid-accumulation clears everything asynchronously. The first branch after deassertion lands in bit 0.
- No state machine beyond the count; states are implied by EMPTY (0), PARTIAL (1..MAP_LEN-1) and FULL (MAP_LEN).
- Assertions (bound, non-synthesised):
  - no branch while full without flush;
  - branches_o ≤ MAP_LEN;
  - map bits ≥ branches_o are zero.

Decomposition:
- trdb_pkg gains:
  - BRANCH_MAP_LEN = 31 and BRANCH_CNT_LEN = 5, used as parameter defaults here and as widths of the emitter's branch_map_i;
  - encoding constants BR_TAKEN = 1'b0 and BR_NOT_TAKEN = 1'b1.
- No sub-module; single flat module, roughly 150 lines including assertions.

Test Plan:
- Reset then no stimulus → map_o=0, branches_o=0, is_empty_o=1, is_full_o=0, overflow_o=0.
- Branches taken, not taken, not taken on consecutive cycles → map_o=0x6, branches_o=3, each update one cycle after its input.
- 31 not-taken branches → map_o=0x7FFFFFFF, branches_o=31, is_full_o=1. Then flush_i with branch taken in the same cycle → map_o=0x0, branches_o=1, overflow_o=0.
- Full map, branch without flush → map/count unchanged, overflow_o high exactly one cycle, assertion fires.
- 5 branches, then rst_ni low mid-stream for 1 cycle, then one not-taken branch → map_o=0x1, branches_o=1.
- Flush while empty, and flush alone after 4 branches → both give map_o=0, branches_o=0, is_empty_o=1 next cycle.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared trace-encoder constants.
// The branch map geometry and the outcome encoding used by the map and the packet emitter.
package trdb_pkg;

    localparam int unsigned BRANCH_MAP_LEN = 31;
    localparam int unsigned BRANCH_CNT_LEN = 5;

    // Branch map bit encoding: a set bit means the branch fell through.
    localparam logic BR_TAKEN     = 1'b0;
    localparam logic BR_NOT_TAKEN = 1'b1;

endpackage

// File: rtl/trdb_branch_map.sv
// Accumulates retired-branch outcomes into the branch map consumed by format 0/1 packets.
// A flush in the same cycle as a branch clears the old map first, so the new outcome lands in bit 0.
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int unsigned MAP_LEN        = BRANCH_MAP_LEN,
    parameter int unsigned CNT_LEN        = BRANCH_CNT_LEN,
    parameter bit          PROTOCOL_CHECK = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               branch_valid_i,
    input  logic               branch_taken_i,
    input  logic               flush_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_LEN-1:0] branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);

    localparam logic [CNT_LEN-1:0] FULL_CNT = CNT_LEN'(MAP_LEN);

    if (2 ** CNT_LEN <= MAP_LEN) begin : g_bad_cnt_len
        $error("CNT_LEN too narrow to hold MAP_LEN");
    end

    logic [MAP_LEN-1:0] map_q, map_d;
    logic [CNT_LEN-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               outcome;

    assign outcome    = branch_taken_i ? BR_TAKEN : BR_NOT_TAKEN;
    assign is_full_o  = (cnt_q == FULL_CNT);
    assign is_empty_o = (cnt_q == '0);

    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (flush_i) begin
            // Emitter has already sampled the pre-flush map this cycle.
            map_d = '0;
            cnt_d = '0;
            if (branch_valid_i) begin
                map_d = MAP_LEN'(outcome);
                cnt_d = CNT_LEN'(1);
            end
        end else if (branch_valid_i) begin
            if (is_full_o) begin
                ovf_d = 1'b1;
            end else begin
                map_d = map_q | (MAP_LEN'(outcome) << cnt_q);
                cnt_d = cnt_q + CNT_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign overflow_o = ovf_q;

    if (PROTOCOL_CHECK) begin : g_protocol_check
        a_no_branch_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(branch_valid_i && !flush_i && is_full_o));
    end

    a_cnt_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= FULL_CNT);

    // Every bit at or above the count must still be clear.
    a_upper_bits_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (map_q >> cnt_q) == '0);

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed-vector bench for trdb_branch_map with hand-computed expectations.
module tb_trdb_branch_map;
    import trdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bv, bt, fl;
    logic [30:0] map;
    logic [4:0]  cnt;
    logic        full, empty, ovf;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // The overflow case below violates the protocol on purpose.
    trdb_branch_map #(.MAP_LEN(31), .CNT_LEN(5), .PROTOCOL_CHECK(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .branch_valid_i(bv), .branch_taken_i(bt),
        .flush_i(fl), .map_o(map), .branches_o(cnt), .is_full_o(full),
        .is_empty_o(empty), .overflow_o(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic t, input logic f);
        bv = v; bt = t; fl = f;
        tick();
    endtask

    task automatic chk_all(input string tag, input logic [30:0] m, input logic [4:0] c,
                           input logic fu, input logic em, input logic ov);
        chk({tag, ".map"}, 32'(map), 32'(m));
        chk({tag, ".cnt"}, 32'(cnt), 32'(c));
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ov));
    endtask

    initial begin
        rst_n = 1'b0; bv = 1'b0; bt = 1'b0; fl = 1'b0;
        #1;
        chk_all("in_reset", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk_all("idle", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // taken, not taken, not taken
        bv = 1'b1; bt = 1'b1; fl = 1'b0;
        #1;
        chk("latency.cnt_before_edge", 32'(cnt), 32'd0);
        tick();
        chk_all("br1", 31'h0, 5'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk_all("br2", 31'h2, 5'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk_all("br3", 31'h6, 5'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk_all("hold", 31'h6, 5'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk_all("br4", 31'hE, 5'd4, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b1);
        chk_all("flush_after4", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk_all("flush_empty", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 1'b0);
        chk_all("fill31", 31'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0);

        drive(1'b1, 1'b1, 1'b0);
        chk_all("overflow", 31'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk_all("overflow_pulse_end", 31'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0);

        drive(1'b1, 1'b1, 1'b1);
        chk_all("full_flush_taken", 31'h0, 5'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk_all("flush_nottaken", 31'h1, 5'd1, 1'b0, 1'b0, 1'b0);

        // five branches total: bit0=1, then nt, t, nt, t -> 0b01011
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk_all("five", 31'h0B, 5'd5, 1'b0, 1'b0, 1'b0);

        bv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 31'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk_all("post_reset_br", 31'h1, 5'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
